// File: rtl/sdram_writer_if.sv
// Avalon-MM write-master bundle used by sdram_writer.
// master: drives address/byte_enable/write/read/write_data, samples acknowledge.
// slave : the bridge side, mirror image of master.
interface sdram_writer_if #(
    parameter int INTERFACE_WIDTH_BITS = 128,
    parameter int INTERFACE_ADDR_BITS  = 26
);
    logic [INTERFACE_ADDR_BITS-1:0]    interface_address;
    logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable;
    logic                              interface_write;
    logic                              interface_read;
    logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data;
    logic                              interface_acknowledge;

    modport master (
        output interface_address,
        output interface_byte_enable,
        output interface_write,
        output interface_read,
        output interface_write_data,
        input  interface_acknowledge
    );

    modport slave (
        input  interface_address,
        input  interface_byte_enable,
        input  interface_write,
        input  interface_read,
        input  interface_write_data,
        output interface_acknowledge
    );
endinterface

// File: rtl/sdram_writer.sv
// Packs an 8-bit byte stream into wide Avalon words and writes them from base_address.
// Ports: interface_clock/reset_n (async active-low), start/base_address/byte_count
// control, s_data/s_valid/s_ready byte stream, avl (Avalon master), busy/done/states.
// Build option: define SDRAM_WRITER_PARTIAL_BE_EN to enable only the filled lanes of
// a final partial word; otherwise the final word is written with all lanes enabled.
module sdram_writer #(
    parameter int INTERFACE_WIDTH_BITS = 128,
    parameter int INTERFACE_ADDR_BITS  = 26,
    parameter int LEN_BITS             = 20
) (
    input  logic                           interface_clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [INTERFACE_ADDR_BITS-1:0] base_address,
    input  logic [LEN_BITS-1:0]            byte_count,
    input  logic [7:0]                     s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    sdram_writer_if.master                 avl,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     states
);
    localparam int LANES     = INTERFACE_WIDTH_BITS / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int AW        = INTERFACE_ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [INTERFACE_WIDTH_BITS-1:0] data_q, data_d;
    logic [LANES-1:0]            be_q, be_d;
    logic [LANE_BITS-1:0]        lane_q, lane_d;
    logic [LEN_BITS-1:0]         rem_q, rem_d;
    logic                        wr_q, wr_d;
    logic                        rdy_q, rdy_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        accept;

    assign accept = s_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_address & ~AW'(LANES - 1);
                    rem_d   = byte_count;
                    lane_d  = '0;
                    data_d  = '0;
                    be_d    = '0;
                    state_d = (byte_count != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (accept) begin
                    data_d[{lane_q, 3'b000} +: 8] = s_data;
                    rem_d  = rem_q - LEN_BITS'(1);
                    lane_d = lane_q + LANE_BITS'(1);
                    // Word is closed by the last lane or by the last byte.
                    if (lane_q == LANE_BITS'(LANES - 1) ||
                        rem_q == LEN_BITS'(1)) begin
                        state_d = WRITE;
`ifdef SDRAM_WRITER_PARTIAL_BE_EN
                        for (int i = 0; i < LANES; i++) begin
                            be_d[i] = (LANE_BITS'(i) <= lane_q);
                        end
`else
                        be_d = '1;
`endif
                    end
                end
            end
            WRITE: begin
                if (avl.interface_acknowledge) begin
                    be_d = '0;
                    if (rem_q != '0) begin
                        // Address wraps naturally at the port width.
                        addr_d  = addr_q + AW'(LANES);
                        data_d  = '0;
                        lane_d  = '0;
                        state_d = FILL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered copies of the next-state decode.
        wr_d   = (state_d == WRITE);
        rdy_d  = (state_d == FILL);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge interface_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            rem_q   <= '0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            wr_q    <= wr_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready                   = rdy_q;
    assign busy                      = busy_q;
    assign done                      = done_q;
    assign states                    = state_q;
    assign avl.interface_address     = addr_q;
    assign avl.interface_byte_enable = be_q;
    assign avl.interface_write       = wr_q;
    assign avl.interface_read        = 1'b0;
    assign avl.interface_write_data  = data_q;
endmodule

// File: tb/tb_sdram_writer.sv
// Directed bench for sdram_writer: table of transfers checked against a byte model,
// plus hand sequences for zero-length start and reset during a write.
module tb_sdram_writer;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [25:0] base_address;
    logic [19:0] byte_count;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        busy;
    logic        done;
    logic [1:0]  states;

    int total;
    int bad;

    sdram_writer_if #(
        .INTERFACE_WIDTH_BITS(128),
        .INTERFACE_ADDR_BITS(26)
    ) avl ();

    sdram_writer #(
        .INTERFACE_WIDTH_BITS(128),
        .INTERFACE_ADDR_BITS(26),
        .LEN_BITS(20)
    ) dut (
        .interface_clock(clk),
        .reset_n(rst_n),
        .start(start),
        .base_address(base_address),
        .byte_count(byte_count),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .avl(avl),
        .busy(busy),
        .done(done),
        .states(states)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [25:0] base;
        int          count;
        logic [7:0]  first;
        int          mode;   // 0 continuous, 1 valid every other cycle
        int          ackd;   // write cycles before ack
        bit          poke;   // pulse start mid-transfer
        int          exp_words;
        logic [25:0] exp_addr0;
        logic [15:0] be_p;   // last-word BE with partial enables
        logic [15:0] be_np;  // last-word BE without
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_word(input vec_t v, input int j);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            if (j * 16 + k < v.count)
                w[k*8 +: 8] = v.first + 8'(j * 16 + k);
        end
        return w;
    endfunction

    task automatic run_vec(input vec_t v);
        int bi, widx, wcyc, ndone;
        bit fin, seen_done, ack;
        logic [127:0] cap_d;
        logic [25:0]  cap_a;
        logic [15:0]  cap_be;
        logic [15:0]  ebe;
        logic [25:0]  ea;
        bi = 0; widx = 0; wcyc = 0; ndone = 0;
        fin = 0; seen_done = 0;
        cap_d = '0; cap_a = '0; cap_be = '0;
        @(posedge clk); #1;
        base_address = v.base;
        byte_count = 20'(v.count);
        start = 1'b1;
        s_valid = 1'b0;
        avl.interface_acknowledge = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (seen_done) begin
                chk("done_one_cycle", done, 0);
                chk("idle_after_done", states, 0);
                fin = 1;
            end
            start = (v.poke && cyc == 3);
            if (start) begin
                base_address = 26'h1234560;
                byte_count = 20'd5;
            end
            ack = 0;
            if (avl.interface_write) begin
                if (wcyc == 0) begin
                    cap_a = avl.interface_address;
                    cap_d = avl.interface_write_data;
                    cap_be = avl.interface_byte_enable;
                end else begin
                    chk("hold_addr", avl.interface_address, cap_a);
                    chk("hold_data", avl.interface_write_data, cap_d);
                    chk("hold_be", avl.interface_byte_enable, cap_be);
                end
                chk("ready_in_write", s_ready, 0);
                if (wcyc >= v.ackd) begin
                    ack = 1;
                    ea = v.exp_addr0 + 26'(16 * widx);
`ifdef SDRAM_WRITER_PARTIAL_BE_EN
                    ebe = (widx == v.exp_words - 1) ? v.be_p : 16'hFFFF;
`else
                    ebe = (widx == v.exp_words - 1) ? v.be_np : 16'hFFFF;
`endif
                    chk("wr_addr", avl.interface_address, ea);
                    chk("wr_data", avl.interface_write_data, exp_word(v, widx));
                    chk("wr_be", avl.interface_byte_enable, ebe);
                    widx++;
                    wcyc = 0;
                end else begin
                    wcyc++;
                end
            end
            avl.interface_acknowledge = ack;
            s_valid = (bi < v.count) && (v.mode == 0 || cyc % 2 == 0);
            s_data = v.first + 8'(bi);
            if (s_valid && s_ready) bi++;
            if (done && !fin) begin
                ndone++;
                chk("done_state", states, 3);
                seen_done = 1;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        avl.interface_acknowledge = 1'b0;
        chk("finished_in_budget", fin, 1);
        chk("write_count", widx, v.exp_words);
        chk("bytes_taken", bi, v.count);
        chk("done_pulses", ndone, 1);
    endtask

    task automatic zero_count();
        @(posedge clk); #1;
        base_address = 26'h900;
        byte_count = 20'd0;
        start = 1'b1;
        avl.interface_acknowledge = 1'b1;
        @(posedge clk); #1;
        chk("z_done", done, 1);
        chk("z_state", states, 3);
        chk("z_no_write", avl.interface_write, 0);
        // Start held high in DONE must be ignored.
        byte_count = 20'd16;
        @(posedge clk); #1;
        start = 1'b0;
        chk("z_done_off", done, 0);
        chk("z_idle", states, 0);
        @(posedge clk); #1;
        chk("z_still_idle", states, 0);
        chk("z_no_write2", avl.interface_write, 0);
        avl.interface_acknowledge = 1'b0;
    endtask

    task automatic reset_mid_write();
        int bi, nw;
        bit seen;
        bi = 0; nw = 0; seen = 0;
        @(posedge clk); #1;
        base_address = 26'h700;
        byte_count = 20'd16;
        start = 1'b1;
        avl.interface_acknowledge = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (avl.interface_write) begin
                seen = 1;
                s_valid = 1'b0;
            end else begin
                s_valid = (bi < 16);
                s_data = 8'(bi);
                if (s_valid && s_ready) bi++;
            end
        end
        chk("r_write_seen", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_write", avl.interface_write, 0);
        chk("r_state", states, 0);
        chk("r_busy", busy, 0);
        chk("r_ready", s_ready, 0);
        chk("r_be", avl.interface_byte_enable, 0);
        chk("r_addr", avl.interface_address, 0);
        chk("r_data", avl.interface_write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        avl.interface_acknowledge = 1'b1;
        s_valid = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (avl.interface_write || busy) nw++;
        end
        chk("r_no_write_after", nw, 0);
        avl.interface_acknowledge = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        vecs[0] = '{26'h100, 32, 8'h00, 0, 1, 0, 2, 26'h100,
                    16'hFFFF, 16'hFFFF};
        vecs[1] = '{26'h200, 16, 8'h40, 0, 5, 1, 1, 26'h200,
                    16'hFFFF, 16'hFFFF};
        vecs[2] = '{26'h30C, 20, 8'hA0, 0, 1, 0, 2, 26'h300,
                    16'h000F, 16'hFFFF};
        vecs[3] = '{26'h500, 16, 8'h10, 1, 2, 0, 1, 26'h500,
                    16'hFFFF, 16'hFFFF};
        vecs[4] = '{26'h3FFFFF0, 32, 8'h80, 0, 0, 0, 2, 26'h3FFFFF0,
                    16'hFFFF, 16'hFFFF};
        vecs[5] = '{26'h40, 1, 8'h5A, 1, 1, 0, 1, 26'h40,
                    16'h0001, 16'hFFFF};

        rst_n = 1'b0;
        start = 1'b0;
        base_address = '0;
        byte_count = '0;
        s_data = '0;
        s_valid = 1'b0;
        avl.interface_acknowledge = 1'b0;
        #1;
        chk("rst_write", avl.interface_write, 0);
        chk("rst_read", avl.interface_read, 0);
        chk("rst_be", avl.interface_byte_enable, 0);
        chk("rst_state", states, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end
        zero_count();
        reset_mid_write();
        chk("read_low", avl.interface_read, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
